imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that fills the instruction memory before the pipelined core starts fetching. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one-cycle word writes to the instruction memory's write port. It holds the core in reset until the last word is written. It is the writer on the instruction-memory interface; the core's fetch stage is the reader.

## Interface
- DEPTH, 64: instruction memory capacity in 32-bit words; the maximum legal word count.
- CNT_W, 16: width of the word-count header field.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  64  byte address of the write; always 4 × word index.
- imem_wdata  output  32  instruction word to write.
- core_hold  output  1  holds the core (pc, IF_ID and the later pipeline registers) in reset while high.
- load_done  output  1  high once all words are written; sticky until reset.
- load_err  output  1  high when the header is illegal; sticky until reset.

## Operation
- Stream format: 2-byte word count N (little-endian, low byte first), then N words of 4 bytes each, least-significant byte first.
- Transfer rule: a byte transfers on a rising edge where in_valid && in_ready. in_data is ignored in every other cycle.
- States and transitions:
  - HDR0: capture count[7:0]; go to HDR1.
  - HDR1: capture count[15:8]. If the full count is 0 or greater than DEPTH, go to ERR. Otherwise go to DATA with word_idx = 0 and byte_idx = 0.
  - DATA: shift each accepted byte into the word register at bit position 8 × byte_idx, then increment byte_idx (2-bit, wraps 3→0). On the 4th byte:
    - register a write for the next cycle: imem_we = 1, imem_addr = {word_idx, 2'b00} zero-extended to 64 bits, imem_wdata = assembled word;
    - increment word_idx;
    - if word_idx + 1 == N, go to FLUSH.
  - FLUSH: the final write is on the bus this cycle; go to DONE.
  - DONE: in_ready = 0, core_hold = 0, load_done = 1. Stays in DONE until reset.
  - ERR: in_ready = 0, core_hold = 1, load_err = 1. Stays in ERR until reset.
- in_ready is 1 exactly in HDR0, HDR1 and DATA.
- Bytes offered in FLUSH, DONE and ERR are not accepted and produce no effect.
- imem_we is never high in two consecutive cycles, because at most one word completes per 4 accepted bytes.
- word_idx width is clog2(DEPTH) + 1 bits. Addresses never exceed 4 × (DEPTH − 1).

## Timing
- Reset values (reset low at a rising edge):
  - state = HDR0
  - in_ready = 1 from the first cycle after reset
  - core_hold = 1
  - imem_we = 0, imem_addr = 0, imem_wdata = 0
  - load_done = 0, load_err = 0
  - byte_idx = 0, word_idx = 0
- Reset asserted mid-load aborts the load. Words already written stay in memory; the next stream starts again at HDR0.
- Write latency: imem_we is high for exactly one cycle, in the cycle after the edge that accepted the word's 4th byte.
- Release latency: core_hold falls one cycle after the final imem_we pulse. The first fetch therefore sees fully written memory.
- Throughput: one byte per cycle with no bubbles, so N words need 2 + 4N transfer cycles plus 2 cycles to reach DONE.
- Gaps (in_valid low) stall the FSM with no state change. A partial word is held indefinitely.
- All outputs are registered except in_ready, which is decoded from the current state.

## Test plan
- Basic load: reset, then stream 02 00 13 05 10 00 93 05 20 00 with in_valid held high -> imem_we pulses at addr 0 with data 0x00100513, then at addr 4 with data 0x00200593; core_hold falls and load_done rises one cycle after the second pulse.
- Bubbles: the same stream with in_valid low on every other cycle -> identical writes, each one cycle after its 4th accepted byte; no extra or missing pulses.
- Zero count: stream 00 00 -> load_err = 1, in_ready = 0, core_hold stays 1, no imem_we; further bytes are ignored.
- Oversize count: with DEPTH = 64, stream 41 00 (65 words) -> ERR. Count 40 00 (64 words) is accepted and the last write lands at addr 0xFC.
- Reset mid-load: drive reset low after 2 bytes of word 1, then stream 01 00 EF BE AD DE -> a single write at addr 0 with data 0xDEADBEEF, then DONE.
- Post-done bytes: after DONE, hold in_valid high with arbitrary bytes for 10 cycles -> in_ready = 0 and no imem_we throughout.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a byte stream into 32-bit instruction-memory writes
// and holds the core in reset until the final word has been written.
module imem_loader #(
   parameter int DEPTH = 64,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        imem_we,
   output logic [63:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_hold,
   output logic        load_done,
   output logic        load_err
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [2:0] {HDR0, HDR1, DATA, FLUSH, DONE, ERR} state_t;
   state_t           state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] hdr;
   logic [AW:0]      word_idx;
   logic [1:0]       byte_idx;
   logic [23:0]      word;
   logic             take;
   logic             last;
   assign in_ready = state == HDR0 || state == HDR1 || state == DATA;
   assign take = in_valid && in_ready;
   assign hdr = CNT_W'({in_data, count[7:0]});
   assign last = CNT_W'(word_idx) + CNT_W'(1) == count;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= HDR0;
         count      <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         word       <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_hold  <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            HDR0: if (take) begin
               count[7:0] <= in_data;
               state      <= HDR1;
            end
            HDR1: if (take) begin
               count    <= hdr;
               word_idx <= '0;
               byte_idx <= '0;
               if (hdr == '0 || hdr > CNT_W'(DEPTH)) begin
                  state    <= ERR;
                  load_err <= 1'b1;
               end else state <= DATA;
            end
            DATA: if (take) begin
               byte_idx <= byte_idx + 2'd1;
               if (byte_idx == 2'd3) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= 64'({word_idx, 2'b00});
                  imem_wdata <= {in_data, word};
                  word_idx   <= word_idx + 1'b1;
                  if (last) state <= FLUSH;
               end else word[{byte_idx, 3'b000} +: 8] <= in_data;
            end
            FLUSH: begin
               state     <= DONE;
               core_hold <= 1'b0;
               load_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, corner sequences and random streams checked against a
// stream-level model of which words get written, where, and on which cycle.
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, imem_we, core_hold, load_done, load_err;
   logic [63:0] imem_addr;
   logic [31:0] imem_wdata;

   imem_loader dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];
   int          rel_cyc;
   always @(negedge clk) begin
      if (!reset) begin
         wa.delete();
         wd.delete();
         wc.delete();
         rel_cyc = -1;
      end else begin
         if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            wc.push_back(cyc);
         end
         if (core_hold === 1'b0 && rel_cyc < 0) rel_cyc = cyc;
      end
   end

   int errors = 0;
   int checks = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [7:0] stim[$];
   int         acc[$];

   task automatic do_reset();
      in_valid = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      chk("reset_flags", {in_ready, core_hold, imem_we, load_done, load_err}, 5'b11000);
      chk("reset_addr", imem_addr, 0);
      chk("reset_wdata", imem_wdata, 0);
   endtask

   task automatic feed(input int bub);
      int  idx = 0;
      int  guard = 0;
      logic v, rdy;
      acc.delete();
      while (idx < stim.size() && in_ready && guard < 2000) begin
         v = $urandom_range(99) >= bub;
         in_valid = v;
         in_data = v ? stim[idx] : 8'($urandom);
         rdy = in_ready;
         @(posedge clk);
         #2;
         if (v && rdy) begin
            acc.push_back(cyc);
            idx++;
         end
         guard++;
      end
      chk("feed_budget", guard < 2000, 1);
      in_valid = 1'b0;
   endtask

   task automatic run(input int bub);
      int n, k;
      bit bad;
      logic [31:0] ew;
      do_reset();
      feed(bub);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data = 8'($urandom);
         @(posedge clk);
         #2;
         if (in_ready !== 1'b0) chk("post_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      n = int'(stim[0]) + 256 * int'(stim[1]);
      bad = n == 0 || n > 64;
      chk("nwrites", wa.size(), bad ? 0 : n);
      for (int i = 0; i < wa.size() && i < (bad ? 0 : n); i++) begin
         k = 2 + 4 * i;
         ew = 32'(stim[k]) + (32'(stim[k+1]) << 8) + (32'(stim[k+2]) << 16) + (32'(stim[k+3]) << 24);
         chk($sformatf("addr%0d", i), wa[i], 64'(4 * i));
         chk($sformatf("data%0d", i), wd[i], ew);
         chk($sformatf("wcyc%0d", i), wc[i], acc.size() > k + 3 ? acc[k+3] : -1);
      end
      chk("final_flags", {in_ready, core_hold, load_done, load_err}, {1'b0, bad, !bad, bad});
      if (!bad && wc.size() > 0) chk("release", rel_cyc, wc[wc.size()-1] + 1);
   endtask

   typedef struct {
      int          len;
      logic [95:0] bs;
      int          bub;
      int          nw;
      logic        done;
      logic        err;
      logic [63:0] la;
      logic [31:0] ld;
   } vec_t;
   vec_t vecs[$];

   initial begin
      vecs.push_back('{10, 96'h00200593_00100513_0002, 0, 2, 1, 0, 64'h4, 32'h00200593});
      vecs.push_back('{10, 96'h00200593_00100513_0002, 50, 2, 1, 0, 64'h4, 32'h00200593});
      vecs.push_back('{4, 96'h2211_0000, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{2, 96'h0041, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{4, 96'h0001_0100, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{6, 96'hDEADBEEF_0001, 30, 1, 1, 0, 64'h0, 32'hDEADBEEF});
      foreach (vecs[j]) begin
         stim.delete();
         for (int i = 0; i < vecs[j].len; i++) stim.push_back(vecs[j].bs[8*i +: 8]);
         run(vecs[j].bub);
         chk($sformatf("vec%0d_nw", j), wa.size(), vecs[j].nw);
         chk($sformatf("vec%0d_done_err", j), {load_done, load_err}, {vecs[j].done, vecs[j].err});
         if (wa.size() > 0) begin
            chk($sformatf("vec%0d_last_addr", j), wa[wa.size()-1], vecs[j].la);
            chk($sformatf("vec%0d_last_data", j), wd[wd.size()-1], vecs[j].ld);
         end
      end
      stim = '{8'h40, 8'h00};
      for (int i = 0; i < 256; i++) stim.push_back(8'($urandom));
      run(10);
      chk("full_last_addr", wa.size() > 0 ? wa[wa.size()-1] : '1, 64'hFC);
      do_reset();
      stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      feed(0);
      repeat (2) @(posedge clk);
      #2;
      chk("midload_nw", wa.size(), 1);
      chk("midload_flags", {in_ready, core_hold, load_done}, 3'b110);
      stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run(0);
      chk("midload_word", wd.size() == 1 ? wd[0] : 32'h0, 32'hDEADBEEF);
      for (int r = 0; r < 14; r++) begin
         int n;
         n = $urandom_range(3) == 0 ? int'($urandom_range(0, 70)) : int'($urandom_range(1, 12));
         if (r == 13) n = 16'h0140;
         stim = '{8'(n), 8'(n >> 8)};
         for (int i = 0; i < 4 * ((n > 64) ? 2 : n); i++) stim.push_back(8'($urandom));
         run($urandom_range(0, 60));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
